adder8_axil_slave: RTL and testbench

AXI4-Lite slave that terminates the master VIP/BFM transactions in the 8-bit adder IP. It exposes operand, control, scratch and launch registers, runs an 8-bit add with carry-in through a fixed-latency pipeline, and exposes the result, status and completion count for readback. It sits directly downstream of the AXI4-Lite master and is the register/compute stage the IP's block design instantiates.

---
 rtl/adder8_axil_pkg.sv | 70 +++++++
 rtl/adder8_core.sv | 59 +++++
 rtl/adder8_axil_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_adder8_axil_slave.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder8_axil_pkg.sv
// adder8_axil_pkg: register map, bit positions, response codes and shared
// helpers for the AXI4-Lite 8-bit adder slave and its compute core.
package adder8_axil_pkg;

    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_ADDR_W = 5;

    // Byte offsets of the eight word registers
    localparam logic [4:0] OFF_A       = 5'h00;
    localparam logic [4:0] OFF_B       = 5'h04;
    localparam logic [4:0] OFF_CTRL    = 5'h08;
    localparam logic [4:0] OFF_SCRATCH = 5'h0C;
    localparam logic [4:0] OFF_GO      = 5'h10;
    localparam logic [4:0] OFF_RESULT  = 5'h14;
    localparam logic [4:0] OFF_STATUS  = 5'h18;
    localparam logic [4:0] OFF_COUNT   = 5'h1C;

    // Word index (address bits [4:2]) of each register
    typedef enum logic [2:0] {
        REG_A       = 3'd0,
        REG_B       = 3'd1,
        REG_CTRL    = 3'd2,
        REG_SCRATCH = 3'd3,
        REG_GO      = 3'd4,
        REG_RESULT  = 3'd5,
        REG_STATUS  = 3'd6,
        REG_COUNT   = 3'd7
    } reg_idx_e;

    localparam int unsigned STATUS_BUSY_BIT    = 0;
    localparam int unsigned STATUS_DONE_BIT    = 1;
    localparam int unsigned STATUS_OVERRUN_BIT = 2;

    localparam int unsigned CTRL_CIN_BIT    = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;

    localparam int unsigned GO_BIT = 0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int unsigned SUM_W         = 8;
    localparam int unsigned RESULT_W      = 10;
    localparam int unsigned RES_CARRY_BIT = 8;
    localparam int unsigned RES_OVF_BIT   = 9;
    localparam int unsigned COUNT_W       = 16;

    // Merge write data into a register, one byte lane per strobe bit
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

    // {overflow, carry, sum} of an 8-bit add with carry-in
    function automatic logic [RESULT_W-1:0] add8(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b,
                                                 input logic             cin);
        logic [SUM_W:0] s;
        logic           ovf;
        s   = {1'b0, a} + {1'b0, b} + {{SUM_W{1'b0}}, cin};
        ovf = (a[SUM_W-1] == b[SUM_W-1]) && (s[SUM_W-1] != a[SUM_W-1]);
        return {ovf, s};
    endfunction

endpackage

// File: rtl/adder8_core.sv
// adder8_core: fixed-latency 8-bit add. Operands are captured when start_i
// is high; a one-hot valid token walks an ADD_LATENCY-deep chain and the
// result register loads on the edge the token leaves the last stage.
// done_pulse_o is high during the cycle whose closing edge completes the op,
// so the parent can update its status on that same edge.
module adder8_core
    import adder8_axil_pkg::*;
#(
    parameter int unsigned ADD_LATENCY = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [SUM_W-1:0]    a_i,
    input  logic [SUM_W-1:0]    b_i,
    input  logic                cin_i,
    output logic                busy_o,
    output logic                done_pulse_o,
    output logic [RESULT_W-1:0] result_o
);

    logic [ADD_LATENCY-1:0] valid_q;
    logic [ADD_LATENCY-1:0] valid_d;
    logic [SUM_W-1:0]       a_q;
    logic [SUM_W-1:0]       b_q;
    logic                   cin_q;
    logic [RESULT_W-1:0]    result_q;

    // Next state of the valid chain: shift in the start request
    always_comb begin
        valid_d = {valid_q[ADD_LATENCY-2:0], start_i};
    end

    // Operand capture, token shift and result load; reset flushes any op
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (start_i) begin
                a_q   <= a_i;
                b_q   <= b_i;
                cin_q <= cin_i;
            end
            if (valid_q[ADD_LATENCY-1]) begin
                result_q <= add8(a_q, b_q, cin_q);
            end
        end
    end

    assign busy_o       = |valid_q;
    assign done_pulse_o = valid_q[ADD_LATENCY-1];
    assign result_o     = result_q;

endmodule

// File: rtl/adder8_axil_slave.sv
// adder8_axil_slave: AXI4-Lite register front end for the 8-bit adder.
// Holds the handshakes, the A/B/CTRL/SCRATCH register file, STATUS/COUNT
// bookkeeping and the GO launch path into adder8_core.
// Optional feature: define ADDER8_IRQ_EN to add the level 'irq' output
// (DONE && CTRL[1]); without it CTRL[1] is plain storage.
module adder8_axil_slave
    import adder8_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned ADD_LATENCY        = 4
) (
`ifdef ADDER8_IRQ_EN
    output logic                            irq,
`endif
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready
);

    // Handshake rules: a transfer happens on a rising edge where both valid
    // and ready are high. awready/wready rise together for one cycle once
    // both awvalid and wvalid are present and no response is pending; the
    // write commits on the edge they are seen high. bvalid then holds with a
    // stable bresp until bready. arready pulses for one cycle when arvalid is
    // present and no read data is pending; rdata is captured on that edge
    // from pre-edge register values and holds with rvalid until rready.

    logic                 awready_q;
    logic                 wready_q;
    logic                 bvalid_q;
    logic [1:0]           bresp_q;
    logic                 arready_q;
    logic                 rvalid_q;
    logic [1:0]           rresp_q;
    logic [31:0]          rdata_q;
    logic [31:0]          rdata_d;

    logic [31:0]          a_q;
    logic [31:0]          b_q;
    logic [31:0]          ctrl_q;
    logic [31:0]          scratch_q;
    logic                 done_q;
    logic                 done_d;
    logic                 overrun_q;
    logic                 overrun_d;
    logic [COUNT_W-1:0]   count_q;
    logic [COUNT_W-1:0]   count_d;

    logic                 wr_fire;
    logic                 rd_fire;
    reg_idx_e             wr_idx;
    reg_idx_e             rd_idx;
    logic                 go_write;
    logic                 go_accept;
    logic                 go_overrun;
    logic                 w1c_done;
    logic                 w1c_overrun;

    logic                 core_busy;
    logic                 core_done;
    logic [RESULT_W-1:0]  core_result;

    // Protection bits and byte-offset bits carry no meaning for this block
    logic unused_addr_prot;
    assign unused_addr_prot = ^{s00_axi_awprot, s00_axi_arprot,
                                s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign wr_idx  = reg_idx_e'(s00_axi_awaddr[4:2]);
    assign rd_idx  = reg_idx_e'(s00_axi_araddr[4:2]);
    assign wr_fire = awready_q && s00_axi_awvalid && wready_q && s00_axi_wvalid;
    assign rd_fire = arready_q && s00_axi_arvalid;

    // GO may launch when idle or on the edge the current op completes
    assign go_write    = wr_fire && (wr_idx == REG_GO) &&
                         s00_axi_wstrb[0] && s00_axi_wdata[GO_BIT];
    assign go_accept   = go_write && (!core_busy || core_done);
    assign go_overrun  = go_write && core_busy && !core_done;
    assign w1c_done    = wr_fire && (wr_idx == REG_STATUS) &&
                         s00_axi_wstrb[0] && s00_axi_wdata[STATUS_DONE_BIT];
    assign w1c_overrun = wr_fire && (wr_idx == REG_STATUS) &&
                         s00_axi_wstrb[0] && s00_axi_wdata[STATUS_OVERRUN_BIT];

    adder8_core #(
        .ADD_LATENCY (ADD_LATENCY)
    ) u_core (
        .clk_i        (s00_axi_aclk),
        .rst_ni       (s00_axi_aresetn),
        .start_i      (go_accept),
        .a_i          (a_q[SUM_W-1:0]),
        .b_i          (b_q[SUM_W-1:0]),
        .cin_i        (ctrl_q[CTRL_CIN_BIT]),
        .busy_o       (core_busy),
        .done_pulse_o (core_done),
        .result_o     (core_result)
    );

    // Write channel: one-cycle ready pulse, then hold the response
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            if (!awready_q && s00_axi_awvalid && s00_axi_wvalid && !bvalid_q) begin
                awready_q <= 1'b1;
                wready_q  <= 1'b1;
            end else begin
                awready_q <= 1'b0;
                wready_q  <= 1'b0;
            end
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= RESP_OKAY;
            end else if (bvalid_q && s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Plain R/W register file with per-byte strobes
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= '0;
            scratch_q <= '0;
        end else if (wr_fire) begin
            case (wr_idx)
                REG_A:       a_q       <= apply_wstrb(a_q, s00_axi_wdata, s00_axi_wstrb);
                REG_B:       b_q       <= apply_wstrb(b_q, s00_axi_wdata, s00_axi_wstrb);
                REG_CTRL:    ctrl_q    <= apply_wstrb(ctrl_q, s00_axi_wdata, s00_axi_wstrb);
                REG_SCRATCH: scratch_q <= apply_wstrb(scratch_q, s00_axi_wdata, s00_axi_wstrb);
                default:     ;
            endcase
        end
    end

    // STATUS/COUNT next state: W1C first, completion/overrun set on top
    always_comb begin
        done_d    = done_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        if (w1c_done)    done_d    = 1'b0;
        if (w1c_overrun) overrun_d = 1'b0;
        if (core_done) begin
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
        end
        if (go_overrun) overrun_d = 1'b1;
    end

    // Sticky status flags and completion counter
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            done_q    <= done_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    // Read data selection from current register values
    always_comb begin
        rdata_d = '0;
        case (rd_idx)
            REG_A:       rdata_d = a_q;
            REG_B:       rdata_d = b_q;
            REG_CTRL:    rdata_d = ctrl_q;
            REG_SCRATCH: rdata_d = scratch_q;
            REG_RESULT:  rdata_d[RESULT_W-1:0] = core_result;
            REG_STATUS: begin
                rdata_d[STATUS_BUSY_BIT]    = core_busy;
                rdata_d[STATUS_DONE_BIT]    = done_q;
                rdata_d[STATUS_OVERRUN_BIT] = overrun_q;
            end
            REG_COUNT:   rdata_d[COUNT_W-1:0] = count_q;
            default:     rdata_d = '0;
        endcase
    end

    // Read channel: one-cycle arready pulse, capture data, hold until rready
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            arready_q <= !arready_q && s00_axi_arvalid && !rvalid_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rresp_q  <= RESP_OKAY;
                rdata_q  <= rdata_d;
            end else if (rvalid_q && s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rdata   = rdata_q;

`ifdef ADDER8_IRQ_EN
    // Level interrupt while DONE is pending and enabled in CTRL
    assign irq = done_q && ctrl_q[CTRL_IRQ_EN_BIT];
`endif

endmodule

// File: tb/tb_adder8_axil_slave.sv
// tb_adder8_axil_slave: directed and randomized AXI4-Lite traffic against
// adder8_axil_slave, with a cycle-indexed register/operation model.
module tb_adder8_axil_slave;

    localparam int unsigned LAT = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [4:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [4:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
`ifdef ADDER8_IRQ_EN
    logic        irq;
`endif

    adder8_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .ADD_LATENCY        (LAT)
    ) dut (
`ifdef ADDER8_IRQ_EN
        .irq             (irq),
`endif
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural state indexed by edge number; ops finish LAT edges after launch.
    logic [31:0] m_reg [4];
    logic        m_done, m_ovr, m_pend;
    int unsigned m_done_cyc;
    logic [7:0]  op_a, op_b;
    logic        op_cin;
    logic [9:0]  m_result;
    logic [15:0] m_count;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_done = 0; m_ovr = 0; m_pend = 0; m_done_cyc = 0;
        op_a = '0; op_b = '0; op_cin = 0;
        m_result = '0; m_count = '0;
    endtask

    task automatic finish_op();
        int u, s;
        u = int'(op_a) + int'(op_b) + int'(op_cin);
        s = int'($signed(op_a)) + int'($signed(op_b)) + int'(op_cin);
        m_result[8:0] = u[8:0];
        m_result[9]   = (s > 127) || (s < -128);
        m_count  = m_count + 16'd1;
        m_done   = 1;
        m_pend   = 0;
    endtask

    task automatic start_op(input int unsigned e);
        op_a   = m_reg[0][7:0];
        op_b   = m_reg[1][7:0];
        op_cin = m_reg[2][0];
        m_pend = 1;
        m_done_cyc = e + LAT;
    endtask

    // Bring model up to the state after edge c
    task automatic model_sync(input int unsigned c);
        if (m_pend && m_done_cyc <= c) finish_op();
    endtask

    task automatic model_write(input int unsigned e, input logic [2:0] idx,
                               input logic [31:0] data, input logic [3:0] strb);
        bit comp, go;
        logic [31:0] mask;
        model_sync(e - 1);
        comp = m_pend && (m_done_cyc == e);
        go   = 0;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        if (idx < 3'd4) begin
            m_reg[idx[1:0]] = (m_reg[idx[1:0]] & ~mask) | (data & mask);
        end else if (idx == 3'd4) begin
            go = strb[0] && data[0];
        end else if (idx == 3'd6 && strb[0]) begin
            if (data[1]) m_done = 0;
            if (data[2]) m_ovr = 0;
        end
        if (comp) finish_op();
        if (go) begin
            if (m_pend) m_ovr = 1;
            else        start_op(e);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: return m_reg[idx[1:0]];
            3'd5: return {22'd0, m_result};
            3'd6: return {29'd0, m_ovr, m_done, m_pend};
            3'd7: return {16'd0, m_count};
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int bdly);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1; wvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(awready && wready) && n < 20);
        check("wr_ready", {30'd0, awready, wready}, 32'd3);
        if (!(awready && wready)) begin
            awvalid = 0; wvalid = 0;
            return;
        end
        model_write(cyc + 1, addr[4:2], data, strb);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        repeat (bdly) @(negedge clk);
        bready = 1;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check("bvalid", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [4:0] addr, input bit use_const, input logic [31:0] cval);
        int n;
        logic [31:0] exp;
        @(negedge clk);
        araddr = addr; arvalid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        check("ar_ready", 32'(arready), 32'd1);
        if (!arready) begin
            arvalid = 0;
            return;
        end
        model_sync(cyc);
        exp = use_const ? cval : model_read(addr[4:2]);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        arvalid = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rready = 1;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        check("rvalid", 32'(rvalid), 32'd1);
        check("rresp", 32'(rresp), 32'd0);
        check($sformatf("rdata@%02h", addr), rdata, exp_q.pop_front());
        @(posedge clk); #1;
        rready = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        checks++;
        failures++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [2:0]  idx;
        model_reset();
        do_reset();

        // reset state of every register
        for (int i = 0; i < 8; i++) axi_read(5'(i * 4), 1, 32'd0);
`ifdef ADDER8_IRQ_EN
        @(negedge clk);
        check("irq_reset", 32'(irq), 32'd0);
`endif

        // plain R/W registers
        axi_write(5'h00, 32'd1, 4'hF, 1);
        axi_write(5'h04, 32'd2, 4'hF, 0);
        axi_write(5'h08, 32'd3, 4'hF, 2);
        axi_write(5'h0C, 32'd4, 4'hF, 0);
        axi_read(5'h00, 1, 32'd1);
        axi_read(5'h04, 1, 32'd2);
        axi_read(5'h08, 1, 32'd3);
        axi_read(5'h0C, 1, 32'd4);
        // partial strobe
        axi_write(5'h0C, 32'hAABBCCDD, 4'b0101, 0);
        axi_read(5'h0C, 1, 32'h00BB00DD);

        // 0xFF + 0x01 -> carry out
        axi_write(5'h00, 32'hFF, 4'hF, 0);
        axi_write(5'h04, 32'h01, 4'hF, 0);
        axi_write(5'h08, 32'h00, 4'hF, 0);
        axi_write(5'h10, 32'h01, 4'h1, 0);
        idle(6);
        axi_read(5'h14, 1, 32'h100);
        axi_read(5'h18, 1, 32'h2);
        axi_read(5'h1C, 1, 32'd1);
        axi_read(5'h10, 1, 32'd0);

        // 0x7F + 0x00 + 1 -> signed overflow; then W1C DONE
        axi_write(5'h00, 32'h7F, 4'hF, 0);
        axi_write(5'h04, 32'h00, 4'hF, 0);
        axi_write(5'h08, 32'h01, 4'hF, 0);
        axi_write(5'h10, 32'h01, 4'h1, 0);
        idle(6);
        axi_read(5'h14, 1, 32'h280);
        axi_write(5'h18, 32'h2, 4'h1, 0);
        axi_read(5'h18, 1, 32'h0);

        // GO while busy -> overrun, one completion; writes to RO ignored
        axi_write(5'h10, 32'h01, 4'h1, 0);
        axi_write(5'h10, 32'h01, 4'h1, 0);
        idle(8);
        axi_read(5'h18, 1, 32'h6);
        axi_read(5'h1C, 1, 32'd3);
        axi_write(5'h14, 32'hFFFFFFFF, 4'hF, 0);
        axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, 0);
        axi_read(5'h14, 1, 32'h280);
        axi_read(5'h1C, 1, 32'd3);

        // reset while an op is in flight
        axi_write(5'h10, 32'h01, 4'h1, 0);
        do_reset();
        idle(6);
        axi_read(5'h1C, 1, 32'd0);
        axi_read(5'h18, 1, 32'd0);
        axi_read(5'h14, 1, 32'd0);

`ifdef ADDER8_IRQ_EN
        // interrupt follows DONE && CTRL[1]
        axi_write(5'h08, 32'h2, 4'hF, 0);
        axi_write(5'h10, 32'h1, 4'h1, 0);
        idle(6);
        check("irq_done", 32'(irq), 32'd1);
        axi_write(5'h18, 32'h2, 4'h1, 0);
        @(negedge clk);
        check("irq_w1c", 32'(irq), 32'd0);
        axi_write(5'h10, 32'h1, 4'h1, 0);
        idle(6);
        check("irq_done2", 32'(irq), 32'd1);
        axi_write(5'h08, 32'h0, 4'hF, 0);
        @(negedge clk);
        check("irq_ctrl_off", 32'(irq), 32'd0);
`endif

        // randomized traffic against the model
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    idx = 3'($urandom_range(0, 7));
                    d   = $urandom;
                    axi_write({idx, 2'b00}, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
                end
                3: axi_write(5'h10, 32'h1, 4'h1, $urandom_range(0, 1));
                4, 5, 6, 7: axi_read(5'($urandom_range(0, 7) * 4), 0, 32'd0);
                8: idle($urandom_range(0, 6));
                default: axi_write(5'h18, 32'h6, 4'h1, 0);
            endcase
        end
        // final sweep of every register
        idle(8);
        for (int i = 0; i < 8; i++) axi_read(5'(i * 4), 0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
